// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results to write-back and runs
// multi-cycle loads/stores against a 16-bit asynchronous SRAM, holding
// upstream stages while an access is in progress.
module mem_stage #(
  parameter int RAM_ADDR_W = 18,
  parameter int WE_PULSE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic [3:0]            reg_addr,
  input  logic [15:0]           alu_result,
  input  logic [15:0]           mem_write_value,
  output logic                  hold,
  output logic                  wb_reg_write,
  output logic [3:0]            wb_reg_addr,
  output logic [15:0]           wb_value,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  output logic                  ram_en_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  // Pulse counter reload: WE_PULSE cycles of ram_we_n low = load value + 1.
  localparam logic [2:0] PULSE_LOAD = 3'(WE_PULSE - 1);

  state_t                  state, state_nx;
  logic [2:0]              cnt, cnt_nx;
  logic                    lat_reg_write, lat_reg_write_nx;
  logic [3:0]              lat_reg_addr, lat_reg_addr_nx;
  logic                    wb_reg_write_nx;
  logic [3:0]              wb_reg_addr_nx;
  logic [15:0]             wb_value_nx;
  logic [RAM_ADDR_W-1:0]   ram_addr_nx;
  logic [15:0]             ram_wdata_nx;
  logic                    ram_en_n_nx, ram_oe_n_nx, ram_we_n_nx;

  assign hold = (state != IDLE);

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_reg_write <= 1'b0;
      lat_reg_addr  <= '0;
      wb_reg_write  <= 1'b0;
      wb_reg_addr   <= '0;
      wb_value      <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      ram_en_n      <= 1'b1;
      ram_oe_n      <= 1'b1;
      ram_we_n      <= 1'b1;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      lat_reg_write <= lat_reg_write_nx;
      lat_reg_addr  <= lat_reg_addr_nx;
      wb_reg_write  <= wb_reg_write_nx;
      wb_reg_addr   <= wb_reg_addr_nx;
      wb_value      <= wb_value_nx;
      ram_addr      <= ram_addr_nx;
      ram_wdata     <= ram_wdata_nx;
      ram_en_n      <= ram_en_n_nx;
      ram_oe_n      <= ram_oe_n_nx;
      ram_we_n      <= ram_we_n_nx;
    end
  end

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    lat_reg_write_nx = lat_reg_write;
    lat_reg_addr_nx  = lat_reg_addr;
    wb_reg_write_nx  = wb_reg_write;
    wb_reg_addr_nx   = wb_reg_addr;
    wb_value_nx      = wb_value;
    ram_addr_nx      = ram_addr;
    ram_wdata_nx     = ram_wdata;
    ram_en_n_nx      = ram_en_n;
    ram_oe_n_nx      = ram_oe_n;
    ram_we_n_nx      = ram_we_n;

    case (state)
      IDLE: begin
        if (flush) begin
          wb_reg_write_nx = 1'b0;
        end else if (mem_write) begin
          // Stores take priority over loads and never write back.
          ram_addr_nx     = RAM_ADDR_W'(alu_result);
          ram_wdata_nx    = mem_write_value;
          ram_en_n_nx     = 1'b0;
          wb_reg_write_nx = 1'b0;
          state_nx        = WR_SETUP;
        end else if (mem_read) begin
          lat_reg_write_nx = reg_write;
          lat_reg_addr_nx  = reg_addr;
          ram_addr_nx      = RAM_ADDR_W'(alu_result);
          ram_en_n_nx      = 1'b0;
          ram_oe_n_nx      = 1'b0;
          wb_reg_write_nx  = 1'b0;
          state_nx         = RD_ADDR;
        end else begin
          wb_reg_write_nx = reg_write;
          wb_reg_addr_nx  = reg_addr;
          wb_value_nx     = alu_result;
        end
      end
      RD_ADDR: begin
        wb_reg_write_nx = 1'b0;
        state_nx        = RD_DATA;
      end
      RD_DATA: begin
        wb_value_nx     = ram_rdata;
        wb_reg_write_nx = lat_reg_write;
        wb_reg_addr_nx  = lat_reg_addr;
        ram_en_n_nx     = 1'b1;
        ram_oe_n_nx     = 1'b1;
        state_nx        = IDLE;
      end
      WR_SETUP: begin
        ram_we_n_nx = 1'b0;
        cnt_nx      = PULSE_LOAD;
        state_nx    = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt != 3'd0) begin
          cnt_nx = cnt - 3'd1;
        end else begin
          ram_we_n_nx = 1'b1;
          state_nx    = WR_HOLD;
        end
      end
      WR_HOLD: begin
        ram_en_n_nx = 1'b1;
        state_nx    = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ID/EX register and execute datapath.
- Consumes the execute result (ALU output, mem_read/mem_write, reg_write/reg_addr, store value).
- Sequences multi-cycle accesses to the external 16-bit data SRAM and stalls upstream via hold while busy.
- Presents registered write-back values to the register file.

Parameters:
RAM_ADDR_W, 18, external SRAM address width; upper bits above 16 driven 0
WE_PULSE, 1, number of cycles ram_we_n is held low during a store (1..7)

Ports:
clk  in  1  core clock, all state changes on posedge
rst  in  1  synchronous active-high reset
flush  in  1  squash the instruction presented this cycle (IDLE only)
mem_read  in  1  load request
mem_write  in  1  store request
reg_write  in  1  instruction writes a register
reg_addr  in  4  destination register
alu_result  in  16  ALU result / effective address
mem_write_value  in  16  store data
hold  out  1  stall request to upstream stages
wb_reg_write  out  1  write-back enable
wb_reg_addr  out  4  write-back register
wb_value  out  16  write-back data
ram_addr  out  RAM_ADDR_W  SRAM address
ram_wdata  out  16  SRAM write data
ram_rdata  in  16  SRAM read data
ram_en_n  out  1  SRAM chip enable, active low
ram_oe_n  out  1  SRAM output enable, active low
ram_we_n  out  1  SRAM write enable, active low

Behaviour:
- Reset values (rst high at posedge):
  - state=IDLE; hold=0; wb_reg_write=0; wb_reg_addr=0; wb_value=0.
  - ram_en_n=1, ram_oe_n=1, ram_we_n=1; ram_addr=0; ram_wdata=0; pulse counter=0.
  - Reset mid-access aborts the access with no write-back; ram_we_n is high from the next cycle.
- hold is combinational: hold = (state != IDLE). Upstream freezes its outputs while hold=1, so the inputs seen on return to IDLE are the next instruction.
- Inputs are ignored in every non-IDLE state, including flush.
- All ram_* and wb_* outputs are registered.
- IDLE, flush=1: bubble. Next cycle wb_reg_write=0; no memory op.
- IDLE, no memory op: pass-through, 1-cycle latency.
  - wb_reg_write<=reg_write, wb_reg_addr<=reg_addr, wb_value<=alu_result. State stays IDLE.
- IDLE, mem_read=1:
  - Latch reg_write and reg_addr.
  - ram_addr<={zero-extend, alu_result}; ram_en_n<=0, ram_oe_n<=0; wb_reg_write<=0.
  - Next state RD_ADDR.
- RD_ADDR: wb_reg_write<=0. Next state RD_DATA.
- RD_DATA:
  - wb_value<=ram_rdata; wb_reg_write<=latched reg_write; wb_reg_addr<=latched reg_addr.
  - ram_en_n<=1, ram_oe_n<=1. Next state IDLE.
  - Load result is valid in the 3rd cycle after the accept edge. hold is high for exactly 2 cycles.
- IDLE, mem_write=1 (wins over mem_read if both set):
  - ram_addr<=alu_result; ram_wdata<=mem_write_value; ram_en_n<=0; ram_we_n stays 1.
  - wb_reg_write<=0 (a store never writes back, even with reg_write=1).
  - Next state WR_SETUP.
- WR_SETUP: ram_we_n<=0; counter<=WE_PULSE-1. Next state WR_PULSE.
- WR_PULSE:
  - counter!=0: decrement and stay.
  - counter==0: ram_we_n<=1, next state WR_HOLD.
  - ram_we_n is low for exactly WE_PULSE cycles.
- WR_HOLD: addr and data remain stable; ram_en_n<=1. Next state IDLE.
- Store: hold high for WE_PULSE+2 cycles.
- ram_addr and ram_wdata never change while ram_we_n=0.
- Address wrap: alu_result 0xFFFF gives ram_addr 0x0FFFF. There is no carry into bit 16.

Test Plan:
- Pass-through: ADDU result 0x1234, reg_write=1, reg_addr=3, no mem op -> next cycle wb_reg_write=1, wb_reg_addr=3, wb_value=0x1234, hold=0 throughout.
- Load: mem_read, alu_result=0x8001, reg_addr=5, SRAM returns 0xBEEF -> ram_addr=0x08001, oe_n low 2 cycles, hold high 2 cycles, then wb_value=0xBEEF to reg 5; the following instruction is processed exactly once.
- Store with WE_PULSE=3: alu_result=0xBF00, data 0x00AA -> ram_we_n low exactly 3 cycles, addr/data stable from setup through hold, hold high 5 cycles, wb_reg_write stays 0.
- Flush: mem_write=1 with flush=1 in IDLE -> no ram_en_n/ram_we_n activity, wb_reg_write=0; flush asserted during RD_DATA is ignored and the load completes.
- Reset mid-store: rst during WR_PULSE -> next cycle ram_we_n=1, ram_en_n=1, state IDLE, hold=0, all wb outputs 0.
- Back-to-back load then store (mem_read and mem_write both set on the store) -> load writes back first, then the store executes as a write with no read cycle.
